poc_result_deserializer: RTL and testbench
==========================================

Name: poc_result_deserializer

Overview:
- Downstream consumer of the proof-of-concept carry-chain core's single-bit result `y_o`.
- Registers the serial result stream and packs enabled samples LSB-first into WORD_W-bit words.
- Buffers completed words in a small FIFO and emits them on a valid/ready interface toward the test-harness readout.
- Also keeps saturating ones and toggle statistics, plus a sticky overflow flag, for timing-closure characterisation runs.

Parameters:
- WORD_W, 8: bits per packed word; must be >= 2.
- FIFO_DEPTH, 4: word FIFO entries; must be a power of 2 and >= 2.
- CNT_W, 16: width of the ones and toggle statistics counters.

Ports:
- clk  in  1  single clock shared with the upstream core.
- rst  in  1  synchronous, active-high reset.
- y_i  in  1  serial result bit from the upstream core.
- en_i  in  1  sample enable; y_i is meaningful only when en_i=1.
- clear_i  in  1  synchronous clear of statistics, overflow and the partial word.
- word_valid_o  out  1  FIFO head word is valid.
- word_data_o  out  WORD_W  FIFO head word.
- word_ready_i  in  1  downstream accepts the head word.
- ones_cnt_o  out  CNT_W  count of enabled samples equal to 1.
- toggle_cnt_o  out  CNT_W  count of enabled samples differing from the previous enabled sample.
- overflow_o  out  1  sticky: a completed word was dropped.
- fill_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0; shift register, bit counter, prev-bit, input stage, FIFO pointers and occupancy all cleared.
- Input stage: y_i and en_i are registered unconditionally into y_q and en_q. All later logic acts on y_q/en_q only.
- Packing: on each edge with en_q=1, y_q is written into word bit position bit_cnt, and bit_cnt increments.
  - When bit_cnt = WORD_W-1 and en_q=1, the completed word {y_q, shreg[WORD_W-2:0]} is pushed in that same edge, and bit_cnt wraps to 0.
  - en_q=0 cycles hold all packing state; gaps are invisible in the word.
- Latency: last bit presented on y_i with en_i=1 in cycle t -> word_valid_o=1 in cycle t+2, provided the FIFO was empty and not full.
- FIFO:
  - word_valid_o = (occupancy != 0); word_data_o = head entry.
  - Pop occurs when word_valid_o && word_ready_i.
  - Push is accepted if occupancy < FIFO_DEPTH, or if a pop happens in the same cycle (full + push + pop: occupancy unchanged, no drop).
  - Push while full with no pop: the word is discarded and overflow_o is set.
  - Pop when empty is impossible, because valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- ones_cnt_o: increments when en_q && y_q; saturates at 2^CNT_W-1.
- toggle_cnt_o: increments when en_q && (y_q != prev_bit); saturates.
  - prev_bit updates to y_q on every en_q=1 edge.
  - prev_bit is 0 after reset or clear.
- overflow_o: sticky; cleared only by rst or clear_i.
- clear_i (synchronous):
  - Zeroes ones/toggle counters, overflow_o, bit_cnt, shift register and prev_bit.
  - Does NOT flush the FIFO and does not block pops.
  - If clear_i and en_q coincide, clear wins and that sample is discarded, including any word completion in that cycle.
- rst mid-operation: the FIFO contents and any partial word are lost; outputs return to reset values on the next edge.
- Simultaneous push and pop on an empty FIFO cannot occur, because valid=0; the word lands and is visible next cycle.

Test Plan:
1. Basic word: after rst, ready=1, en_i=1, bits 1,0,1,1,0,0,1,0 (LSB-first) -> word_data_o=0x4D with word_valid_o high 2 cycles after the last bit, for one cycle; ones_cnt_o=4; toggle_cnt_o=6; overflow_o=0.
2. Backpressure/overflow: ready=0, 40 consecutive enabled 1s -> fill_level_o=4 holding four 0xFF words; the fifth word is dropped; overflow_o=1; ones_cnt_o=40. Then ready=1 -> exactly four 0xFF words transfer, then valid=0 and overflow_o stays 1.
3. Full-with-pop: FIFO at 4 entries; assert ready so a pop coincides with the push edge of a 0xA5 word -> no overflow, fill_level_o stays 4, and 0xA5 emerges last in order.
4. Enable gaps: the scenario-1 bits interleaved with en_i=0 cycles carrying y_i=1 -> word still 0x4D; ones_cnt_o=4.
5. Clear mid-word: 3 enabled bits, then clear_i for one cycle concurrent with an enabled bit, then bits 0xF0 pattern LSB-first -> next word 0xF0; counters reflect only post-clear bits (ones=4, toggles=1); earlier FIFO contents intact.
6. Saturation: CNT_W=4, 20 enabled alternating bits 1,0,... -> ones_cnt_o=10, toggle_cnt_o=15 (saturated). With 20 enabled 1s -> ones_cnt_o=15.

Source files
------------

// File: rtl/poc_result_deserializer_if.sv
// Readout handshake between the result deserializer and the test-harness reader.
//   word_valid_o : head word available (driven by the deserializer)
//   word_data_o  : head word, WORD_W bits (driven by the deserializer)
//   word_ready_i : reader accepts the head word (driven by the reader)
// master = word source (deserializer), slave = word sink (reader).
interface poc_result_deserializer_if #(parameter int WORD_W = 8);
   logic              word_valid_o;
   logic [WORD_W-1:0] word_data_o;
   logic              word_ready_i;

   modport master (output word_valid_o, output word_data_o, input word_ready_i);
   modport slave  (input word_valid_o, input word_data_o, output word_ready_i);
endinterface

// File: rtl/poc_result_deserializer.sv
// Deserializer for the carry-chain core's serial result bit.
// Registers y_i/en_i, packs enabled samples LSB-first into WORD_W-bit words,
// buffers finished words in a FIFO_DEPTH-entry FIFO read out over a
// valid/ready interface, and keeps saturating ones/toggle statistics plus a
// sticky overflow flag for a dropped word.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   y_i, en_i     : serial result bit and its sample enable
//   clear_i       : clears statistics, overflow and the partial word (not the FIFO)
//   rd            : word readout handshake (master side)
//   ones_cnt_o    : enabled samples equal to 1 (saturating)
//   toggle_cnt_o  : enabled samples differing from the previous enabled sample (saturating)
//   overflow_o    : sticky, a completed word was dropped on a full FIFO
//   fill_level_o  : FIFO occupancy
module poc_result_deserializer #(
   parameter int WORD_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          y_i,
   input  logic                          en_i,
   input  logic                          clear_i,
   poc_result_deserializer_if.master     rd,
   output logic [CNT_W-1:0]              ones_cnt_o,
   output logic [CNT_W-1:0]              toggle_cnt_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(WORD_W);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

   logic              y_q, en_q, prev_bit;
   logic [WORD_W-1:0] shreg;
   logic [BW-1:0]     bit_cnt;
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;

   logic              complete, pop, full, push, drop;
   logic [WORD_W-1:0] push_word;

   // A clear in the same cycle as an enabled sample discards that sample,
   // including a word that would otherwise complete on this edge.
   assign complete  = en_q && !clear_i && (bit_cnt == LAST_BIT);
   assign push_word = {y_q, shreg[WORD_W-2:0]};
   assign pop       = (count != '0) && rd.word_ready_i;
   assign full      = (count == DEPTH_C);
   // A full FIFO still accepts the word when the head leaves on the same edge.
   assign push      = complete && (!full || pop);
   assign drop      = complete && full && !pop;

   assign rd.word_valid_o = (count != '0);
   assign rd.word_data_o  = mem[rd_ptr];
   assign fill_level_o    = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q  <= 1'b0;
         en_q <= 1'b0;
      end else begin
         y_q  <= y_i;
         en_q <= en_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         shreg        <= '0;
         bit_cnt      <= '0;
         prev_bit     <= 1'b0;
         ones_cnt_o   <= '0;
         toggle_cnt_o <= '0;
         overflow_o   <= 1'b0;
      end else begin
         if (en_q) begin
            shreg[bit_cnt] <= y_q;
            bit_cnt        <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
            prev_bit       <= y_q;
            if (y_q && (ones_cnt_o != '1))
               ones_cnt_o <= ones_cnt_o + CNT_W'(1);
            if ((y_q != prev_bit) && (toggle_cnt_o != '1))
               toggle_cnt_o <= toggle_cnt_o + CNT_W'(1);
         end
         if (drop)
            overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_poc_result_deserializer.sv
module tb_poc_result_deserializer;
   localparam int W   = 8;
   localparam int D   = 4;
   localparam int CW  = 16;
   localparam int CWS = 4;
   localparam int SAT  = (1 << CW) - 1;
   localparam int SATS = (1 << CWS) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, y = 1'b0, en = 1'b0, clr = 1'b0, rdy = 1'b0;

   poc_result_deserializer_if #(.WORD_W(W)) rd_if ();
   poc_result_deserializer_if #(.WORD_W(W)) rd_s ();
   assign rd_if.word_ready_i = rdy;
   assign rd_s.word_ready_i  = rdy;

   logic [CW-1:0]  ones, togs;
   logic [CWS-1:0] ones_s, togs_s;
   logic           ovf, ovf_s;
   logic [2:0]     fill, fill_s;

   poc_result_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .y_i(y), .en_i(en), .clear_i(clr), .rd(rd_if),
      .ones_cnt_o(ones), .toggle_cnt_o(togs), .overflow_o(ovf), .fill_level_o(fill));

   poc_result_deserializer #(.WORD_W(W), .FIFO_DEPTH(D), .CNT_W(CWS)) dut_s (
      .clk(clk), .rst(rst), .y_i(y), .en_i(en), .clear_i(clr), .rd(rd_s),
      .ones_cnt_o(ones_s), .toggle_cnt_o(togs_s), .overflow_o(ovf_s), .fill_level_o(fill_s));

   int checks = 0;
   int errors = 0;

   // Reference model: samples as a list of bits, FIFO as a queue of words.
   logic [W-1:0] m_fifo[$];
   logic [W-1:0] m_popped[$];
   logic [W-1:0] d_popped[$];
   bit           m_part[$];
   int           m_ones, m_tog, s_ones, s_tog;
   bit           m_ovf, m_prev, m_yq, m_enq;

   function automatic void model_edge();
      bit pop_m, done;
      logic [W-1:0] wd;
      done = 1'b0;
      wd = '0;
      if (rst) begin
         m_fifo.delete(); m_part.delete();
         m_ones = 0; m_tog = 0; s_ones = 0; s_tog = 0;
         m_ovf = 0; m_prev = 0; m_yq = 0; m_enq = 0;
         return;
      end
      pop_m = (m_fifo.size() != 0) && rdy;
      if (clr) begin
         m_part.delete();
         m_ones = 0; m_tog = 0; s_ones = 0; s_tog = 0;
         m_ovf = 0; m_prev = 0;
      end else if (m_enq) begin
         if (m_yq) begin
            if (m_ones < SAT)  m_ones++;
            if (s_ones < SATS) s_ones++;
         end
         if (m_yq != m_prev) begin
            if (m_tog < SAT)  m_tog++;
            if (s_tog < SATS) s_tog++;
         end
         m_prev = m_yq;
         m_part.push_back(m_yq);
         if (m_part.size() == W) begin
            for (int i = 0; i < W; i++) wd[i] = m_part[i];
            m_part.delete();
            done = 1'b1;
         end
      end
      if (pop_m) m_popped.push_back(m_fifo.pop_front());
      if (done) begin
         if (m_fifo.size() < D) m_fifo.push_back(wd);
         else m_ovf = 1'b1;
      end
      m_yq = y;
      m_enq = en;
   endfunction

   task automatic step(input bit yv, input bit ev, input bit cv, input bit rv);
      @(negedge clk);
      y = yv; en = ev; clr = cv; rdy = rv;
      #1;
      if (!rst && rd_if.word_valid_o && rdy) d_popped.push_back(rd_if.word_data_o);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      rst = 1'b0;
      m_popped.delete();
      d_popped.delete();
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit rv);
      for (int i = 0; i < W; i++) step(w[i], 1, 0, rv);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rd_if.word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rd_if.word_valid_o); end
      checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
      checks++; if ({ones, togs} !== '0) begin errors++; $display("FAIL reset_cnts: got %0d/%0d expected 0/0", ones, togs); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
      checks++; if (rd_if.word_data_o !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", rd_if.word_data_o); end
   endtask

   task automatic test_basic();
      do_reset();
      send_word(8'h4D, 1);
      checks++; if (rd_if.word_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0", rd_if.word_valid_o); end
      step(0, 0, 0, 1);
      checks++; if (rd_if.word_valid_o !== 1'b1 || rd_if.word_data_o !== 8'h4D)
         begin errors++; $display("FAIL basic_word: got v=%0b d=%0h expected v=1 d=4d", rd_if.word_valid_o, rd_if.word_data_o); end
      step(0, 0, 0, 1);
      checks++; if (rd_if.word_valid_o !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %0b expected 0", rd_if.word_valid_o); end
      checks++; if (ones !== 16'd4 || togs !== 16'd6 || ovf !== 1'b0)
         begin errors++; $display("FAIL basic_stats: got ones=%0d tog=%0d ovf=%0b expected 4 6 0", ones, togs, ovf); end
      checks++; if (ones !== CW'(m_ones) || togs !== CW'(m_tog))
         begin errors++; $display("FAIL basic_model: got %0d/%0d expected %0d/%0d", ones, togs, m_ones, m_tog); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      checks++; if (fill !== 3'd4 || ovf !== 1'b1 || ones !== 16'd40 || rd_if.word_data_o !== 8'hFF)
         begin errors++; $display("FAIL ovf_full: got fill=%0d ovf=%0b ones=%0d d=%0h expected 4 1 40 ff", fill, ovf, ones, rd_if.word_data_o); end
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
      checks++; if (d_popped.size() != 4) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 4", d_popped.size()); end
      foreach (d_popped[i]) begin
         checks++; if (d_popped[i] !== 8'hFF) begin errors++; $display("FAIL ovf_drain_word: got %0h expected ff", d_popped[i]); end
      end
      checks++; if (rd_if.word_valid_o !== 1'b0 || ovf !== 1'b1)
         begin errors++; $display("FAIL ovf_sticky: got v=%0b ovf=%0b expected 0 1", rd_if.word_valid_o, ovf); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 32; i++) step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      checks++; if (fill !== 3'd4) begin errors++; $display("FAIL fullpop_pre: got %0d expected 4", fill); end
      send_word(8'hA5, 0);
      step(0, 0, 0, 1);
      checks++; if (fill !== 3'd4 || ovf !== 1'b0)
         begin errors++; $display("FAIL fullpop_level: got fill=%0d ovf=%0b expected 4 0", fill, ovf); end
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
      checks++; if (d_popped.size() != 5) begin errors++; $display("FAIL fullpop_count: got %0d expected 5", d_popped.size()); end
      else begin
         checks++; if (d_popped[4] !== 8'hA5 || d_popped[3] !== 8'hFF)
            begin errors++; $display("FAIL fullpop_order: got %0h,%0h expected ff,a5", d_popped[3], d_popped[4]); end
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] w;
      do_reset();
      w = 8'h4D;
      for (int i = 0; i < W; i++) begin
         step(w[i], 1, 0, 1);
         step(1, 0, 0, 1);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      checks++; if (d_popped.size() != 1) begin errors++; $display("FAIL gaps_count: got %0d expected 1", d_popped.size()); end
      else begin
         checks++; if (d_popped[0] !== 8'h4D) begin errors++; $display("FAIL gaps_word: got %0h expected 4d", d_popped[0]); end
      end
      checks++; if (ones !== 16'd4) begin errors++; $display("FAIL gaps_ones: got %0d expected 4", ones); end
   endtask

   task automatic test_clear();
      logic [W-1:0] p;
      do_reset();
      p = W'($urandom);
      send_word(p, 0);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      step(0, 0, 1, 0);
      send_word(8'hF0, 0);
      step(0, 0, 0, 0);
      checks++; if (fill !== 3'd2 || ovf !== 1'b0)
         begin errors++; $display("FAIL clear_fill: got fill=%0d ovf=%0b expected 2 0", fill, ovf); end
      checks++; if (ones !== 16'd4 || togs !== 16'd1)
         begin errors++; $display("FAIL clear_stats: got ones=%0d tog=%0d expected 4 1", ones, togs); end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
      checks++; if (d_popped.size() != 2) begin errors++; $display("FAIL clear_count: got %0d expected 2", d_popped.size()); end
      else begin
         checks++; if (d_popped[0] !== p || d_popped[1] !== 8'hF0)
            begin errors++; $display("FAIL clear_words: got %0h,%0h expected %0h,f0", d_popped[0], d_popped[1], p); end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) step(((i % 2) == 0), 1, 0, 1);
      step(0, 0, 0, 1);
      checks++; if (ones_s !== 4'd10 || togs_s !== 4'd15)
         begin errors++; $display("FAIL sat_alt: got ones=%0d tog=%0d expected 10 15", ones_s, togs_s); end
      checks++; if (ones !== 16'd10 || togs !== 16'd20)
         begin errors++; $display("FAIL sat_alt_wide: got ones=%0d tog=%0d expected 10 20", ones, togs); end
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 1, 0, 1);
      step(0, 0, 0, 1);
      checks++; if (ones_s !== 4'd15) begin errors++; $display("FAIL sat_ones: got %0d expected 15", ones_s); end
   endtask

   task automatic test_random();
      int bad;
      do_reset();
      bad = 0;
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 1), ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
              ($urandom_range(0, 2) == 0));
         checks++;
         if (fill !== 3'(m_fifo.size()) || rd_if.word_valid_o !== (m_fifo.size() != 0) || ovf !== m_ovf ||
             ones !== CW'(m_ones) || togs !== CW'(m_tog) || ones_s !== CWS'(s_ones) || togs_s !== CWS'(s_tog) ||
             (m_fifo.size() != 0 && rd_if.word_data_o !== m_fifo[0])) begin
            errors++;
            if (bad < 5)
               $display("FAIL rand_cycle %0d: got fill=%0d ovf=%0b ones=%0d tog=%0d expected fill=%0d ovf=%0b ones=%0d tog=%0d",
                        c, fill, ovf, ones, togs, m_fifo.size(), m_ovf, m_ones, m_tog);
            bad++;
         end
      end
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
      checks++; if (d_popped.size() != m_popped.size())
         begin errors++; $display("FAIL rand_pop_count: got %0d expected %0d", d_popped.size(), m_popped.size()); end
      else begin
         foreach (m_popped[i]) begin
            checks++; if (d_popped[i] !== m_popped[i])
               begin errors++; $display("FAIL rand_word %0d: got %0h expected %0h", i, d_popped[i], m_popped[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_gaps();
      test_clear();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
